// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, default baud divider and the
// parity helper. Used by both the transmitter and the receiver so that
// state encodings stay identical across the two directions.
package uart_pkg;

    // Default divider: 25 MHz system clock / 115200 baud.
    localparam int UART_CLKS_PER_BIT_DFLT = 217;

    // Frame state encoding, common to TX and RX.
    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        START   = 3'b001,
        DATA    = 3'b010,
        PARITY  = 3'b011,
        STOP    = 3'b100,
        CLEANUP = 3'b101
    } uart_state_t;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Baud-rate divider. Counts 0..CLKS_PER_BIT-1 and raises bit_tick during the
// last count of each bit period; the count wraps to 0 on the same edge.
// A synchronous clear holds the count at 0 so every bit period starts aligned.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] count_r;

    // Bit-period counter: cleared on request, wraps after the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else if (clear) begin
            count_r <= CNT_ZERO;
        end else if (count_r == CNT_LAST) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign bit_tick = (count_r == CNT_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter. Accepts one byte per i_TX_DV/o_TX_Ready handshake and
// sends it LSB first as start + 8 data + [parity] + STOP_BITS stop bits.
// Optional even parity is compiled in with the macro UART_TX_PARITY_EN
// (8E1/8E2); without it the frame is 8N1/8N2.
// All outputs are flops; the line is forced high asynchronously by rst_n.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DFLT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done
);

    localparam logic [2:0] BIT_LAST  = 3'd7;
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t state_r;
    logic [7:0]  shift_r;
    logic [2:0]  bit_idx_r;
    logic        tx_serial_r;
    logic        tx_ready_r;
    logic        tx_active_r;
    logic        tx_done_r;
`ifdef UART_TX_PARITY_EN
    logic        parity_r;
`endif
    logic        accept_s;
    logic        clear_s;
    logic        bit_tick_s;

    assign accept_s = i_TX_DV & tx_ready_r;

    // Hold the baud counter at zero whenever no bit is being timed, so the
    // first bit period after IDLE starts from a clean count.
    always_comb begin
        clear_s = 1'b1;
        case (state_r)
            START:   clear_s = 1'b0;
            DATA:    clear_s = 1'b0;
`ifdef UART_TX_PARITY_EN
            PARITY:  clear_s = 1'b0;
`endif
            STOP:    clear_s = 1'b0;
            default: clear_s = 1'b1;
        endcase
    end

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_s),
        .bit_tick (bit_tick_s)
    );

    // Frame sequencer: owns the state, the shift register and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            shift_r     <= 8'h00;
            bit_idx_r   <= 3'd0;
            tx_serial_r <= 1'b1;
            tx_ready_r  <= 1'b1;
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    tx_serial_r <= 1'b1;
                    tx_done_r   <= 1'b0;
                    if (accept_s) begin
                        // Latch everything the frame needs; later bus changes are ignored.
                        shift_r     <= i_TX_Byte;
`ifdef UART_TX_PARITY_EN
                        parity_r    <= even_parity(i_TX_Byte);
`endif
                        bit_idx_r   <= 3'd0;
                        tx_serial_r <= 1'b0;
                        tx_ready_r  <= 1'b0;
                        tx_active_r <= 1'b1;
                        state_r     <= START;
                    end else begin
                        tx_ready_r  <= 1'b1;
                        tx_active_r <= 1'b0;
                    end
                end

                START: begin
                    if (bit_tick_s) begin
                        tx_serial_r <= shift_r[0];
                        shift_r     <= {1'b0, shift_r[7:1]};
                        bit_idx_r   <= 3'd0;
                        state_r     <= DATA;
                    end
                end

                DATA: begin
                    if (bit_tick_s) begin
                        if (bit_idx_r == BIT_LAST) begin
                            bit_idx_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            tx_serial_r <= parity_r;
                            state_r     <= PARITY;
`else
                            tx_serial_r <= 1'b1;
                            state_r     <= STOP;
`endif
                        end else begin
                            tx_serial_r <= shift_r[0];
                            shift_r     <= {1'b0, shift_r[7:1]};
                            bit_idx_r   <= bit_idx_r + 3'd1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick_s) begin
                        tx_serial_r <= 1'b1;
                        bit_idx_r   <= 3'd0;
                        state_r     <= STOP;
                    end
                end
`endif

                STOP: begin
                    // bit_idx_r is reused here to count stop bits.
                    if (bit_tick_s) begin
                        if (bit_idx_r == STOP_LAST) begin
                            tx_active_r <= 1'b0;
                            tx_done_r   <= 1'b1;
                            bit_idx_r   <= 3'd0;
                            state_r     <= CLEANUP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end

                CLEANUP: begin
                    tx_serial_r <= 1'b1;
                    tx_done_r   <= 1'b0;
                    tx_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end

                default: begin
                    state_r     <= IDLE;
                    bit_idx_r   <= 3'd0;
                    tx_serial_r <= 1'b1;
                    tx_ready_r  <= 1'b1;
                    tx_active_r <= 1'b0;
                    tx_done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_TX_Serial = tx_serial_r;
    assign o_TX_Ready  = tx_ready_r;
    assign o_TX_Active = tx_active_r;
    assign o_TX_Done   = tx_done_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT=4. Table of bytes with
// hand-computed send order and parity, plus sequences for back-to-back
// accepts, ignored mid-frame strobes, reset mid-frame and two stop bits.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL  = (9 + P + 1) * CPB;
    localparam int FL2 = (9 + P + 2) * CPB;
    localparam int PER = FL + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv_s = 1'b0;
    logic [7:0] byte_s = 8'h00;
    logic       ready_s, serial_s, active_s, done_s;
    logic       dv2_s = 1'b0;
    logic [7:0] byte2_s = 8'h00;
    logic       ready2_s, serial2_s, active2_s, done2_s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] order;   // send order, bit 7 = first data bit on the line
        logic       par;
        int         glitch;  // offset of an ignored DV pulse, -1 for none
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_TX_DV(dv_s), .i_TX_Byte(byte_s),
        .o_TX_Ready(ready_s), .o_TX_Serial(serial_s),
        .o_TX_Active(active_s), .o_TX_Done(done_s)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_TX_DV(dv2_s), .i_TX_Byte(byte2_s),
        .o_TX_Ready(ready2_s), .o_TX_Serial(serial2_s),
        .o_TX_Active(active2_s), .o_TX_Done(done2_s)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected line level at offset o after the accept edge.
    function automatic logic exp_bit(input logic [7:0] order, input logic par, input int o);
        if (o < CPB) return 1'b0;
        else if (o < 9 * CPB) return order[7 - (o - CPB) / CPB];
`ifdef UART_TX_PARITY_EN
        else if (o < 10 * CPB) return par;
`endif
        else return 1'b1;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7 - i] = b[i];
        return r;
    endfunction

    function automatic logic [7:0] byte_for(input int c);
        return 8'(c * 29 + 7);
    endfunction

    // Send one byte on dut and check every cycle of the frame plus idle tail.
    task automatic frame_check(input vec_t v);
        @(negedge clk);
        chk("ready_before_accept", ready_s, 1'b1);
        dv_s = 1'b1;
        byte_s = v.data;
        @(posedge clk); #1;
        for (int o = 0; o < FL + 8; o++) begin
            chk("serial", serial_s, exp_bit(v.order, v.par, o));
            chk("done", done_s, (o == FL));
            chk("ready", ready_s, (o > FL));
            chk("active", active_s, (o < FL));
            @(negedge clk);
            if (o + 1 == v.glitch) begin
                dv_s = 1'b1;
                byte_s = 8'h3C;
            end else begin
                dv_s = 1'b0;
                byte_s = ~v.data ^ 8'(o);
            end
            @(posedge clk); #1;
        end
        dv_s = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'b10100101, 1'b0, 14};
        vecs[1] = '{8'h07, 8'b11100000, 1'b1, -1};
        vecs[2] = '{8'h03, 8'b11000000, 1'b0, -1};
        vecs[3] = '{8'h3C, 8'b00111100, 1'b0, 30};
        vecs[4] = '{8'h81, 8'b10000001, 1'b0, -1};
        vecs[5] = '{8'h5A, 8'b01011010, 1'b0, -1};
        vecs[6] = '{8'h01, 8'b10000000, 1'b1, 3};
        vecs[7] = '{8'h80, 8'b00000001, 1'b1, -1};

        // Reset state, during and after reset.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_serial", serial_s, 1'b1);
        chk("rst_ready", ready_s, 1'b1);
        chk("rst_active", active_s, 1'b0);
        chk("rst_done", done_s, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_serial", serial_s, 1'b1);
        chk("idle_ready", ready_s, 1'b1);
        chk("idle2_serial", serial2_s, 1'b1);
        chk("idle2_ready", ready2_s, 1'b1);
        chk("idle2_active", active2_s, 1'b0);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) frame_check(vecs[i]);

        // DV held high, byte changing every cycle: back-to-back frames.
        for (int c = 0; c < 3 * PER; c++) begin
            logic [7:0] b;
            int o;
            @(negedge clk);
            dv_s = 1'b1;
            byte_s = byte_for(c);
            @(posedge clk); #1;
            o = c % PER;
            b = byte_for((c / PER) * PER);
            chk("b2b_serial", serial_s, exp_bit(rev8(b), ^b, o));
            chk("b2b_done", done_s, (o == FL));
            chk("b2b_ready", ready_s, (o == FL + 1));
            chk("b2b_active", active_s, (o < FL));
        end
        @(negedge clk);
        dv_s = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("b2b_end_serial", serial_s, 1'b1);
            chk("b2b_end_ready", ready_s, 1'b1);
        end

        // Reset during data bit 3 of 8'hFF.
        @(negedge clk);
        dv_s = 1'b1;
        byte_s = 8'hFF;
        @(posedge clk); #1;
        @(negedge clk);
        dv_s = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("ff_bit3_active", active_s, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_serial", serial_s, 1'b1);
        chk("rst_mid_ready", ready_s, 1'b1);
        chk("rst_mid_active", active_s, 1'b0);
        chk("rst_mid_done", done_s, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < FL + 4; j++) begin
            @(posedge clk); #1;
            chk("post_rst_done", done_s, 1'b0);
            chk("post_rst_serial", serial_s, 1'b1);
        end

        // Reset during the start bit: line must rise before the next edge.
        @(negedge clk);
        dv_s = 1'b1;
        byte_s = 8'h00;
        @(posedge clk); #1;
        chk("start_low", serial_s, 1'b0);
        @(negedge clk);
        dv_s = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_start_serial", serial_s, 1'b1);
        chk("rst_start_ready", ready_s, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_start_idle", serial_s, 1'b1);

        // Two stop bits, byte 8'h00.
        @(negedge clk);
        dv2_s = 1'b1;
        byte2_s = 8'h00;
        @(posedge clk); #1;
        for (int o = 0; o < FL2 + 4; o++) begin
            chk("s2_serial", serial2_s, (o >= (9 + P) * CPB));
            chk("s2_done", done2_s, (o == FL2));
            chk("s2_ready", ready2_s, (o > FL2));
            chk("s2_active", active2_s, (o < FL2));
            @(negedge clk);
            dv2_s = 1'b0;
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
